// File: rtl/sprite_loader.sv
// ---------------------------------------------------------------------------
// sprite_loader
//
// Write-side companion to the sprite RAM. Consumes a byte stream from the
// host link and assembles two bytes per pixel into 9-bit RGB333 words,
// which are written to the RAM in address order. One load covers PIXELS
// pixels. After the last pixel the block pulses done and returns to idle.
//
// Byte order per pixel: the first byte supplies pixel bit 8 in its bit 0
// (bits 7:1 are ignored). The second byte supplies pixel bits 7:0.
//
// Optional build macro: SPRITE_LOADER_CHECKSUM_EN
//   When defined, a running 8-bit XOR covers every pixel byte. One trailing
//   byte is consumed after the last pixel. err is set when that byte does
//   not match the XOR, and it holds until the next start.
//   When undefined, err is tied to 0.
//
// Ports
//   CLK        in   rising-edge clock
//   RST        in   synchronous active-high reset
//   start      in   one-cycle pulse; begins a load at address 0 (idle only)
//   in_data    in   stream byte
//   in_valid   in   in_data valid
//   in_ready   out  byte accepted this cycle when in_valid is also high
//   wr_en      out  RAM write strobe, one cycle per pixel
//   wr_addr    out  RAM write address
//   wr_data    out  pixel {R[2:0],G[2:0],B[2:0]}
//   busy       out  load in progress
//   done       out  one-cycle pulse at load completion
//   err        out  checksum mismatch (checksum build only)
// ---------------------------------------------------------------------------
module sprite_loader #(
    parameter int PIXELS = 1024,
    parameter int ADDR_W = $clog2(PIXELS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [8:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_WR,
        S_CHK,
        S_FIN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              hi_bit;
    logic              accept;
    logic              last_px;

    // in_ready is decoded from the state register alone, so there is no
    // combinational path from in_valid to in_ready.
    assign in_ready = (state == S_HI) || (state == S_LO) || (state == S_CHK);
    assign busy     = (state != S_IDLE);
    assign accept   = in_valid && in_ready;
    assign last_px  = (cnt == ADDR_W'(PIXELS - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start)  state_nxt = S_HI;
            S_HI:   if (accept) state_nxt = S_LO;
            S_LO:   if (accept) state_nxt = S_WR;
            S_WR: begin
                // The terminal test comes before the increment, so the
                // counter never wraps during a load.
                if (last_px) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
                    state_nxt = S_CHK;
`else
                    state_nxt = S_FIN;
`endif
                end else begin
                    state_nxt = S_HI;
                end
            end
            S_CHK:  if (accept) state_nxt = S_FIN;
            S_FIN:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            cnt     <= '0;
            hi_bit  <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            // The write strobe is registered, so it is high exactly while
            // the state register holds WR.
            wr_en <= (state == S_LO) && accept;
            done  <= (state_nxt == S_FIN);
            if ((state == S_IDLE) && start)
                cnt <= '0;
            if ((state == S_HI) && accept)
                hi_bit <= in_data[0];
            if ((state == S_LO) && accept) begin
                wr_addr <= cnt;
                wr_data <= {hi_bit, in_data};
            end
            if ((state == S_WR) && !last_px)
                cnt <= cnt + 1'b1;
        end
    end

`ifdef SPRITE_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic       err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            csum  <= 8'h00;
            err_q <= 1'b0;
        end else if ((state == S_IDLE) && start) begin
            csum  <= 8'h00;
            err_q <= 1'b0;
        end else if (((state == S_HI) || (state == S_LO)) && accept) begin
            // The XOR covers the full byte, including the ignored bits 7:1
            // of the high byte.
            csum <= csum ^ in_data;
        end else if ((state == S_CHK) && accept) begin
            err_q <= (in_data != csum);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
